// File: rtl/serial_queue_pkg.sv
// Shared types and defaults for the serial-in word queue.
// SERIAL_QUEUE_SYNC_EN selects two-flop input synchronizers (adds 2 cycles of latency).
package serial_queue_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic [0:0] {
    COLLECT    = 1'b0,
    WORD_READY = 1'b1
  } asm_state_e;

  // Clocks after reset release before an edge may be reported; covers the sync pipeline fill.
`ifdef SERIAL_QUEUE_SYNC_EN
  localparam logic [1:0] ARM_CYCLES = 2'd3;
`else
  localparam logic [1:0] ARM_CYCLES = 2'd1;
`endif

endpackage

// File: rtl/serial_queue_param_edge_detect.sv
// Rising-edge pulse generator for one strobe, with optional two-flop synchronizer.
// SERIAL_QUEUE_SYNC_EN inserts the synchronizer ahead of the edge detector.
module edge_detect
  import serial_queue_pkg::*;
(
  input  logic clock_1MHz,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic       level;
  logic       prev;
  logic [1:0] arm_cnt;
  logic       armed;

`ifdef SERIAL_QUEUE_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], sig};
    end
  end

  assign level = sync[1];
`else
  assign level = sig;
`endif

  // A strobe already high when reset releases is absorbed into prev before edges are armed.
  assign armed = (arm_cnt == ARM_CYCLES);
  assign rise  = level & ~prev & armed;

  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      prev    <= 1'b0;
      arm_cnt <= 2'd0;
    end else begin
      prev <= level;
      if (!armed) begin
        arm_cnt <= arm_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/serial_queue_param.sv
// Serial bit assembler feeding a DEPTH-word register FIFO, with sticky error flags.
// SERIAL_QUEUE_SYNC_EN adds two-flop synchronizers on all serial/strobe inputs.
module serial_queue_param
  import serial_queue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       clock_1MHz,
  input  logic                       rst,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       enqueue_in,
  input  logic                       dequeue_in,
  input  logic                       err_clr_in,
  output logic                       status_out,
  output logic [DATA_W-1:0]          data_out,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic                       overflow_out,
  output logic                       underflow_out,
  output logic                       frame_err_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int BC_W  = $clog2(DATA_W) + 1;

  logic              data_bit;
  logic              wr_rise;
  logic              enq_rise;
  logic              deq_rise;

  asm_state_e        state;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] shreg;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              pop_ok;
  logic              push_ok;
  logic              frame_set;
  logic              ovf_set;
  logic              unf_set;
  logic [CNT_W-1:0]  next_count;

`ifdef SERIAL_QUEUE_SYNC_EN
  logic [1:0] data_sync;

  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      data_sync <= 2'b00;
    end else begin
      data_sync <= {data_sync[0], data_in};
    end
  end

  assign data_bit = data_sync[1];
`else
  assign data_bit = data_in;
`endif

  edge_detect u_wr_edge (
    .clock_1MHz (clock_1MHz),
    .rst        (rst),
    .sig        (write_in),
    .rise       (wr_rise)
  );

  edge_detect u_enq_edge (
    .clock_1MHz (clock_1MHz),
    .rst        (rst),
    .sig        (enqueue_in),
    .rise       (enq_rise)
  );

  edge_detect u_deq_edge (
    .clock_1MHz (clock_1MHz),
    .rst        (rst),
    .sig        (dequeue_in),
    .rise       (deq_rise)
  );

  // A pop on a full queue frees the slot, so a coincident push still lands.
  assign pop_ok    = deq_rise && !empty_out;
  assign push_ok   = enq_rise && (state == WORD_READY) && (!full_out || pop_ok);
  assign ovf_set   = enq_rise && (state == WORD_READY) && full_out && !pop_ok;
  assign unf_set   = deq_rise && empty_out;
  assign frame_set = (wr_rise && (state == WORD_READY)) ||
                     (enq_rise && (state == COLLECT));

  always_comb begin
    next_count = count_out;
    if (push_ok && !pop_ok) begin
      next_count = count_out + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      next_count = count_out - CNT_W'(1);
    end
  end

  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      count_out  <= '0;
      full_out   <= 1'b0;
      empty_out  <= 1'b1;
      status_out <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_out   <= '0;
    end else begin
      count_out  <= next_count;
      full_out   <= (next_count == CNT_W'(DEPTH));
      empty_out  <= (next_count == '0);
      status_out <= (next_count != CNT_W'(DEPTH));
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clock_1MHz) begin
    if (push_ok) begin
      mem[wr_ptr] <= shreg;
    end
  end

  // Enqueue always closes the current frame; a bit arriving in the same cycle is dropped.
  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      state   <= COLLECT;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (enq_rise) begin
      state   <= COLLECT;
      bit_cnt <= '0;
    end else if (wr_rise && (state == COLLECT)) begin
      shreg[bit_cnt[BC_W-2:0]] <= data_bit;
      bit_cnt                  <= bit_cnt + BC_W'(1);
      if (bit_cnt == BC_W'(DATA_W - 1)) begin
        state <= WORD_READY;
      end
    end
  end

  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
      frame_err_out <= 1'b0;
    end else if (err_clr_in) begin
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow_out <= 1'b1;
      end
      if (unf_set) begin
        underflow_out <= 1'b1;
      end
      if (frame_set) begin
        frame_err_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_queue_param.sv
// Directed bench for serial_queue_param: scoreboard of dequeued words plus status checks.
`timescale 1ns/1ps
module tb_serial_queue_param;

  localparam int DW = 8;
  localparam int DP = 8;
`ifdef SERIAL_QUEUE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  localparam int OP_BITS  = 0;
  localparam int OP_ENQ   = 1;
  localparam int OP_DEQ   = 2;
  localparam int OP_CLR   = 3;
  localparam int OP_COINC = 4;

  logic          clock_1MHz = 1'b0;
  logic          rst        = 1'b0;
  logic          data_in    = 1'b0;
  logic          write_in   = 1'b0;
  logic          enqueue_in = 1'b0;
  logic          dequeue_in = 1'b0;
  logic          err_clr_in = 1'b0;
  logic          status_out;
  logic [DW-1:0] data_out;
  logic [3:0]    count_out;
  logic          full_out;
  logic          empty_out;
  logic          overflow_out;
  logic          underflow_out;
  logic          frame_err_out;

  int            total = 0;
  int            bad   = 0;
  logic [7:0]    sb[$];
  logic [7:0]    model_q[$];
  logic [7:0]    last_word = 8'h00;
  logic [7:0]    asm_word  = 8'h00;
  int            asm_bits  = 0;
  logic [7:0]    mon_exp;

  serial_queue_param #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clock_1MHz    (clock_1MHz),
    .rst           (rst),
    .data_in       (data_in),
    .write_in      (write_in),
    .enqueue_in    (enqueue_in),
    .dequeue_in    (dequeue_in),
    .err_clr_in    (err_clr_in),
    .status_out    (status_out),
    .data_out      (data_out),
    .count_out     (count_out),
    .full_out      (full_out),
    .empty_out     (empty_out),
    .overflow_out  (overflow_out),
    .underflow_out (underflow_out),
    .frame_err_out (frame_err_out)
  );

  always #500 clock_1MHz = ~clock_1MHz;

  task automatic tick(input int n);
    repeat (n) @(negedge clock_1MHz);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_pop();
    if (model_q.size() > 0) begin
      last_word = model_q.pop_front();
    end
    sb.push_back(last_word);
  endtask

  // Each strobe is held 5 us high then 5 us low, i.e. a 10 us strobe period.
  task automatic applyStimulus(input int op, input logic [7:0] word, input int nbits);
    case (op)
      OP_BITS: begin
        if (asm_bits == 0 && nbits == 8) begin
          asm_word = word;
          asm_bits = 8;
        end else if (asm_bits < 8) begin
          asm_bits = (asm_bits + nbits > 8) ? 8 : asm_bits + nbits;
        end
        for (int i = 0; i < nbits; i++) begin
          data_in  = word[i];
          write_in = 1'b1;
          tick(5);
          write_in = 1'b0;
          tick(5);
        end
      end
      OP_ENQ: begin
        if (asm_bits == 8 && model_q.size() < DP) model_q.push_back(asm_word);
        asm_bits   = 0;
        enqueue_in = 1'b1;
        tick(5);
        enqueue_in = 1'b0;
        tick(5);
      end
      OP_DEQ: begin
        model_pop();
        dequeue_in = 1'b1;
        tick(5);
        dequeue_in = 1'b0;
        tick(5);
      end
      OP_CLR: begin
        err_clr_in = 1'b1;
        tick(2);
        err_clr_in = 1'b0;
        tick(2);
      end
      default: begin
        model_pop();
        if (asm_bits == 8) model_q.push_back(asm_word);
        asm_bits   = 0;
        data_in    = word[0];
        write_in   = 1'b1;
        enqueue_in = 1'b1;
        dequeue_in = 1'b1;
        tick(5);
        write_in   = 1'b0;
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
        tick(5);
      end
    endcase
  endtask

  task automatic send_and_enqueue(input logic [7:0] word);
    applyStimulus(OP_BITS, word, 8);
    applyStimulus(OP_ENQ, 8'h00, 0);
  endtask

  initial begin : monitor
    forever begin
      @(posedge dequeue_in);
      repeat (LAT) @(posedge clock_1MHz);
      #1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_dequeue: got data_out %0h with no expected word", data_out);
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("data_out", 32'(data_out), 32'(mon_exp));
      end
    end
  end

  initial begin : stimulus
    tick(3);
    checkOutput("rst_count", 32'(count_out), 32'd0);
    checkOutput("rst_empty", 32'(empty_out), 32'd1);
    checkOutput("rst_full", 32'(full_out), 32'd0);
    checkOutput("rst_status", 32'(status_out), 32'd1);
    checkOutput("rst_data", 32'(data_out), 32'd0);
    checkOutput("rst_flags", 32'({overflow_out, underflow_out, frame_err_out}), 32'd0);
    rst = 1'b1;
    tick(3);

    send_and_enqueue(8'h80);
    checkOutput("first_count", 32'(count_out), 32'd1);
    checkOutput("first_empty", 32'(empty_out), 32'd0);
    checkOutput("first_frame", 32'(frame_err_out), 32'd0);

    for (int w = 8'h81; w <= 8'h87; w++) send_and_enqueue(8'(w));
    checkOutput("fill_full", 32'(full_out), 32'd1);
    checkOutput("fill_status", 32'(status_out), 32'd0);
    checkOutput("fill_count", 32'(count_out), 32'd8);
    checkOutput("fill_ovf", 32'(overflow_out), 32'd0);
    send_and_enqueue(8'h88);
    checkOutput("ovf_flag", 32'(overflow_out), 32'd1);
    checkOutput("ovf_count", 32'(count_out), 32'd8);

    for (int i = 0; i < 8; i++) applyStimulus(OP_DEQ, 8'h00, 0);
    checkOutput("drain_empty", 32'(empty_out), 32'd1);
    applyStimulus(OP_DEQ, 8'h00, 0);
    checkOutput("unf_flag", 32'(underflow_out), 32'd1);
    checkOutput("unf_count", 32'(count_out), 32'd0);
    checkOutput("unf_data_hold", 32'(data_out), 32'h87);
    applyStimulus(OP_CLR, 8'h00, 0);
    checkOutput("clr_flags", 32'({overflow_out, underflow_out}), 32'd0);

    for (int w = 8'h80; w <= 8'h87; w++) send_and_enqueue(8'(w));
    checkOutput("refill_full", 32'(full_out), 32'd1);
    applyStimulus(OP_BITS, 8'hA5, 8);
    applyStimulus(OP_COINC, 8'h01, 1);
    checkOutput("coinc_count", 32'(count_out), 32'd8);
    checkOutput("coinc_full", 32'(full_out), 32'd1);
    checkOutput("coinc_data", 32'(data_out), 32'h80);
    checkOutput("coinc_ovf", 32'(overflow_out), 32'd0);
    checkOutput("coinc_frame", 32'(frame_err_out), 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(OP_DEQ, 8'h00, 0);
    checkOutput("wrap_empty", 32'(empty_out), 32'd1);
    applyStimulus(OP_CLR, 8'h00, 0);

    applyStimulus(OP_BITS, 8'h1F, 5);
    applyStimulus(OP_ENQ, 8'h00, 0);
    checkOutput("partial_frame", 32'(frame_err_out), 32'd1);
    checkOutput("partial_count", 32'(count_out), 32'd0);
    applyStimulus(OP_CLR, 8'h00, 0);
    checkOutput("partial_clr", 32'(frame_err_out), 32'd0);

    send_and_enqueue(8'hC1);
    send_and_enqueue(8'hC2);
    send_and_enqueue(8'hC3);
    applyStimulus(OP_DEQ, 8'h00, 0);
    applyStimulus(OP_BITS, 8'h0F, 4);
    checkOutput("pre_reset_count", 32'(count_out), 32'd2);

    rst        = 1'b0;
    write_in   = 1'b1;
    data_in    = 1'b1;
    enqueue_in = 1'b1;
    tick(2);
    model_q.delete();
    asm_bits  = 0;
    last_word = 8'h00;
    rst       = 1'b1;
    tick(4);
    write_in   = 1'b0;
    enqueue_in = 1'b0;
    data_in    = 1'b0;
    tick(5);
    checkOutput("mid_reset_count", 32'(count_out), 32'd0);
    checkOutput("mid_reset_data", 32'(data_out), 32'd0);
    checkOutput("mid_reset_empty", 32'(empty_out), 32'd1);
    checkOutput("held_strobe_frame", 32'(frame_err_out), 32'd0);

    send_and_enqueue(8'h3C);
    checkOutput("post_reset_count", 32'(count_out), 32'd1);
    applyStimulus(OP_DEQ, 8'h00, 0);
    checkOutput("post_reset_empty", 32'(empty_out), 32'd1);
    checkOutput("post_reset_unf", 32'(underflow_out), 32'd0);

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d words left expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_queue_param.md
SERIAL_QUEUE_PARAM -- requirements
Module: serial_queue_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits per word assembled from data_in.
REQ-002 SHALL have parameter DEPTH, default 8, power of two and at least 2: queue capacity in words.
REQ-003 SHALL have port clock_1MHz, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port data_in, input, 1 bit: serial data bit, sampled on a write_in rising edge.
REQ-006 SHALL have port write_in, input, 1 bit: bit strobe, level-held for many cycles; only its rising edge acts.
REQ-007 SHALL have port enqueue_in, input, 1 bit: push strobe; only its rising edge acts.
REQ-008 SHALL have port dequeue_in, input, 1 bit: pop strobe; only its rising edge acts.
REQ-009 SHALL have port err_clr_in, input, 1 bit: level; clears all sticky error flags while high.
REQ-010 SHALL have port status_out, output, 1 bit: ready, equal to not full.
REQ-011 SHALL have port data_out, output, DATA_W bits: last dequeued word, registered.
REQ-012 SHALL have port count_out, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-013 SHALL have ports full_out and empty_out, output, 1 bit each: occupancy equals DEPTH, and occupancy equals 0.
REQ-014 SHALL have ports overflow_out, underflow_out and frame_err_out, output, 1 bit each: sticky error flags.

Function
REQ-015 SHALL detect each strobe's rising edge as (current sample AND NOT previous sample) and act on the clock edge where the rising edge is detected.
REQ-016 SHALL implement an assembler FSM with states COLLECT and WORD_READY, plus a bit counter of width $clog2(DATA_W)+1.
REQ-017 SHALL, in COLLECT on a write_in edge, store data_in at shift-register index bit_cnt (LSB first) and increment bit_cnt; on reaching DATA_W it SHALL go to WORD_READY.
REQ-018 SHALL, in WORD_READY, ignore further write_in edges and set frame_err.
REQ-019 SHALL, on an enqueue edge in COLLECT (partial word), push nothing, set frame_err, and clear bit_cnt.
REQ-020 SHALL, on an enqueue edge in WORD_READY when not full, write the word at the write pointer, then go to COLLECT with bit_cnt equal to 0.
REQ-021 SHALL, on an enqueue edge in WORD_READY when full and with no simultaneous dequeue, discard the word, set overflow, and go to COLLECT.
REQ-022 SHALL, on a dequeue edge when not empty, load data_out with the word at the read pointer one cycle after edge detection, and advance the read pointer.
REQ-023 SHALL, on a dequeue edge when empty, hold data_out and set underflow.
REQ-024 SHALL, on simultaneous valid push and pop edges in the same cycle, perform both with count unchanged; this SHALL hold when full (the pop frees the slot) and SHALL NOT hold when empty (the pop is an underflow and only the push occurs).
REQ-025 SHALL use read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-026 SHALL keep count_out, full_out, empty_out and status_out registered and consistent in the same cycle.
REQ-027 SHALL give err_clr_in priority over a flag being set in the same cycle.

Reset
REQ-028 SHALL, while rst is low, immediately force: pointers 0, count 0, bit_cnt 0, FSM COLLECT, shift register 0, data_out 0, all error flags 0, and edge-detect history 0.
REQ-029 SHALL hold reset values during reset: empty_out 1, full_out 0, status_out 1.
REQ-030 SHALL lose any partial word and all queued words when reset is asserted mid-operation.
REQ-031 SHALL NOT report a strobe held high across reset release as an edge.

Configuration
REQ-032 SHALL, when macro SERIAL_QUEUE_SYNC_EN is defined, pass data_in, write_in, enqueue_in and dequeue_in through two-flop synchronizers before edge detection, adding 2 cycles of latency to every action.
REQ-033 SHALL, without SERIAL_QUEUE_SYNC_EN, sample the inputs directly, with edge detection on the first clock after the rising edge.

Structure
REQ-034 SHALL place the assembler state enum (COLLECT, WORD_READY) and the defaults DATA_W_DEF = 8 and DEPTH_DEF = 8 in package serial_queue_pkg.
REQ-035 SHALL implement one sub-module, edge_detect (optional synchronizer plus rising-edge pulse), instantiated once per strobe.
REQ-036 SHALL implement the storage as an internal register array of DEPTH entries by DATA_W bits, with no memory macro.

Verification
REQ-037 SHALL cover: send 8'h80 LSB first (10 us bit strobes), then an enqueue pulse -> count_out 1, empty_out 0, frame_err_out 0.
REQ-038 SHALL cover: enqueue 8'h80..8'h87 -> full_out 1 and status_out 0; a 9th word 8'h88 -> overflow_out 1 and count_out 8.
REQ-039 SHALL cover: 8 dequeues after the fill -> data_out shows 8'h80..8'h87 in order; a 9th dequeue -> underflow_out 1 and data_out still 8'h87.
REQ-040 SHALL cover: full queue with write_in/enqueue/dequeue edges coincident in one cycle -> count stays 8, data_out 8'h80, word stored at the wrapped slot, no overflow.
REQ-041 SHALL cover: 5 bits then an enqueue -> frame_err_out 1 and count unchanged; err_clr_in pulse -> frame_err_out 0.
REQ-042 SHALL cover: reset pulse after 3 words and 4 bits -> count_out 0, data_out 0; then a full new word enqueues correctly.
